fmap_collector: RTL
===================

# fmap_collector

- Streaming feature-map sink placed after the convolution layer.
- Accepts one pixel per beat in raster order and assembles a complete IMGROW×IMGCOL frame in flop storage.
- Presents the frame as a 2D array with a valid/ack handshake to the next layer.
- Optionally ping-pongs two banks so input streaming continues while the downstream holds a frame.

## Interface

Parameters:
- IMGROW, 32, frame rows
- IMGCOL, 32, frame columns
- DATA_WIDTH, 8, pixel width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  pixel beat valid
- in_data  in  DATA_WIDTH  pixel value
- in_sof  in  1  marks first pixel of a frame, qualified by in_valid
- in_ready  out  1  sink can accept a beat
- fmap  out  DATA_WIDTH × [IMGROW][IMGCOL] unpacked  presented frame
- fmap_valid  out  1  fmap holds a complete frame
- fmap_ack  in  1  downstream releases the presented frame
- frame_cnt  out  16  completed frames, wraps at 2^16
- err_sof  out  1  sticky error flag; in_sof seen mid-frame

## Operation

- Beat accepted when in_valid && in_ready. Pixel written to [row][col] of the write bank.
- Pointer update per beat: col+1. At col=IMGCOL-1: col←0, row+1.
- At row=IMGROW-1, col=IMGCOL-1:
  - pointers←0
  - write bank state EMPTY→FULL
  - frame_cnt+1
- in_sof on accepted beat with pointers at (0,0): normal.
- in_sof on accepted beat with pointers not at (0,0) (resync):
  - err_sof←1
  - partial frame abandoned; bank contents not cleared
  - beat written to [0][0]; pointers→(0,1)
- in_sof absent on the first beat of a frame is not an error.
- Bank states are EMPTY and FULL only; a bank is FILL implicitly while it is the write bank and EMPTY.
- in_ready = write bank EMPTY. Derived from registered state only, never from in_valid.
- fmap_valid = read bank FULL. fmap = read bank contents.
- fmap_ack while fmap_valid=1: read bank→EMPTY. fmap_ack while fmap_valid=0 is ignored.
- Arithmetic:
  - row width $clog2(IMGROW), col width $clog2(IMGCOL)
  - pointers never exceed IMGROW-1 / IMGCOL-1
  - frame_cnt wraps modulo 2^16
- Reset values (any time, including mid-frame):
  - fmap all 0, fmap_valid 0, in_ready 1, frame_cnt 0, err_sof 0
  - pointers 0, all banks EMPTY, bank selects 0
  - partial frame discarded
- err_sof clears only on reset.

## Timing

- Pixel write takes effect on the clock edge where the beat is accepted.
- fmap_valid rises the cycle after the last pixel is accepted. The full frame is visible on fmap in that same cycle.
- Frame latency from first accepted beat: IMGROW×IMGCOL cycles at full rate + 1.
- Ack release: fmap_valid falls the cycle after fmap_ack, unless another bank is FULL.
- in_ready recovers the cycle after the ack that frees the write bank.
- Backpressure on in_valid is allowed at any beat. Gaps do not disturb the pointers.

## Configuration

- FMAP_DOUBLE_BUF_EN defined: two banks with wr_sel / rd_sel.
  - Completing a frame toggles wr_sel.
  - Ack toggles rd_sel.
  - in_ready drops only when both banks are FULL.
  - Completion into one bank and ack of the other in the same cycle both take effect: fmap_valid stays 1 and fmap switches to the new frame next cycle.
  - Ack when both banks are FULL: the next frame is presented the following cycle, and in_ready returns the same cycle.
- FMAP_DOUBLE_BUF_EN undefined: single bank.
  - in_ready=0 from the cycle after completion until the cycle after ack.
  - Simultaneous completion and ack is impossible.

## Structure

- Package fmap_pkg holds:
  - bank_state_t enum {BANK_EMPTY, BANK_FULL}
  - FRAME_CNT_W = 16
  - pointer-width localparam helper functions
- Sub-module fmap_bank: one frame of storage with write-address decode and async reset. Instantiated once or twice under FMAP_DOUBLE_BUF_EN.
- Top level owns the pointers, bank state, selects, handshake, counter and error flag.

## Test plan

All scenarios use IMGROW=4, IMGCOL=4.
- Reset then stream values 0..15 with in_sof on the first beat, no stalls:
  - fmap_valid=1 at cycle 17
  - fmap[r][c]=4r+c
  - frame_cnt=1, err_sof=0
- Same stream with in_valid toggled every other cycle: identical fmap content; fmap_valid rises the cycle after beat 15.
- Single buffer, no ack, send a second frame:
  - in_ready=0 after completion
  - fmap_ack pulse → fmap_valid=0 next cycle, in_ready=1 next cycle
  - second frame lands intact
- Double buffer, no ack, send frames A then B:
  - in_ready stays 1 through B
  - fmap stays showing A
  - in_ready=0 after B completes
  - ack → fmap shows B next cycle, fmap_valid stays 1
- Send 6 beats, then in_sof with value 0xAA followed by 15 beats:
  - err_sof=1 after the in_sof beat
  - fmap[0][0]=0xAA
  - frame completes after 16 beats counted from the in_sof beat
- Assert rst mid-frame at beat 9:
  - all outputs at reset values
  - next 16-beat frame completes normally with frame_cnt=1

Source files
------------

// File: rtl/fmap_pkg.sv
// fmap_collector shared types: bank state, counter width, pointer widths.
package fmap_pkg;

    typedef enum logic {
        BANK_EMPTY = 1'b0,
        BANK_FULL  = 1'b1
    } bank_state_t;

    localparam int FRAME_CNT_W = 16;

    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fmap_bank.sv
// One frame of flop storage with row/col write decode.
module fmap_bank
    import fmap_pkg::*;
#(
    parameter int IMGROW     = 32,
    parameter int IMGCOL     = 32,
    parameter int DATA_WIDTH = 8,
    localparam int RW        = ptr_w(IMGROW),
    localparam int CW        = ptr_w(IMGCOL)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [RW-1:0]         i_row,
    input  logic [CW-1:0]         i_col,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_fmap [IMGROW][IMGCOL]
);

    logic [DATA_WIDTH-1:0] r_mem [IMGROW][IMGCOL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < IMGROW; r++)
                for (int c = 0; c < IMGCOL; c++)
                    r_mem[r][c] <= '0;
        end else if (i_we) begin
            r_mem[i_row][i_col] <= i_data;
        end
    end

    assign o_fmap = r_mem;

endmodule

// File: rtl/fmap_collector.sv
// Streaming feature-map sink; FMAP_DOUBLE_BUF_EN enables ping-pong banks.
module fmap_collector
    import fmap_pkg::*;
#(
    parameter int IMGROW     = 32,
    parameter int IMGCOL     = 32,
    parameter int DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_sof,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  fmap [IMGROW][IMGCOL],
    output logic                   fmap_valid,
    input  logic                   fmap_ack,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic                   err_sof
);

    localparam int RW = ptr_w(IMGROW);
    localparam int CW = ptr_w(IMGCOL);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMGROW - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMGCOL - 1);
`ifdef FMAP_DOUBLE_BUF_EN
    localparam int NBANK = 2;
`else
    localparam int NBANK = 1;
`endif

    logic [RW-1:0]          r_row;
    logic [CW-1:0]          r_col;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_err_sof;
    // Two state slots always; the second stays EMPTY in single-bank builds.
    bank_state_t            r_state [2];

    logic                   w_wsel;
    logic                   w_rsel;
    logic                   w_acc;
    logic                   w_resync;
    logic                   w_last;
    logic                   w_ack;
    logic [RW-1:0]          w_wrow;
    logic [CW-1:0]          w_wcol;
    logic [DATA_WIDTH-1:0]  w_bank [NBANK][IMGROW][IMGCOL];

    assign in_ready   = (r_state[w_wsel] == BANK_EMPTY);
    assign fmap_valid = (r_state[w_rsel] == BANK_FULL);
    assign frame_cnt  = r_frame_cnt;
    assign err_sof    = r_err_sof;

    assign w_acc    = in_valid && in_ready;
    assign w_resync = w_acc && in_sof && (r_row != '0 || r_col != '0);
    assign w_wrow   = w_resync ? '0 : r_row;
    assign w_wcol   = w_resync ? '0 : r_col;
    assign w_last   = w_acc && (w_wrow == ROW_LAST) && (w_wcol == COL_LAST);
    assign w_ack    = fmap_ack && fmap_valid;

`ifdef FMAP_DOUBLE_BUF_EN
    logic r_wr_sel;
    logic r_rd_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_last) r_wr_sel <= ~r_wr_sel;
            if (w_ack)  r_rd_sel <= ~r_rd_sel;
        end
    end

    assign w_wsel = r_wr_sel;
    assign w_rsel = r_rd_sel;
`else
    assign w_wsel = 1'b0;
    assign w_rsel = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (w_acc) begin
            if (w_wcol == COL_LAST) begin
                r_col <= '0;
                r_row <= (w_wrow == ROW_LAST) ? '0 : w_wrow + 1'b1;
            end else begin
                r_col <= w_wcol + 1'b1;
                r_row <= w_wrow;
            end
        end
    end

    // Completing bank is EMPTY and acked bank is FULL, so they never collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < 2; b++)
                r_state[b] <= BANK_EMPTY;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_last && w_wsel == 1'(b))
                    r_state[b] <= BANK_FULL;
                else if (w_ack && w_rsel == 1'(b))
                    r_state[b] <= BANK_EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= '0;
            r_err_sof   <= 1'b0;
        end else begin
            if (w_last)   r_frame_cnt <= r_frame_cnt + 1'b1;
            if (w_resync) r_err_sof   <= 1'b1;
        end
    end

    for (genvar b = 0; b < NBANK; b++) begin : g_bank
        fmap_bank #(
            .IMGROW     (IMGROW),
            .IMGCOL     (IMGCOL),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .i_we   (w_acc && w_wsel == 1'(b)),
            .i_row  (w_wrow),
            .i_col  (w_wcol),
            .i_data (in_data),
            .o_fmap (w_bank[b])
        );
    end

    always_comb begin
        for (int r = 0; r < IMGROW; r++)
            for (int c = 0; c < IMGCOL; c++)
`ifdef FMAP_DOUBLE_BUF_EN
                fmap[r][c] = w_rsel ? w_bank[1][r][c] : w_bank[0][r][c];
`else
                fmap[r][c] = w_bank[0][r][c];
`endif
    end

endmodule
